// File: rtl/ldq_alloc_ctrl_pkg.sv
// Shared load/store-queue sizing constants for the load-queue allocation controller.
package ldq_alloc_ctrl_pkg;

   localparam int unsigned LDQ_DEPTH = 16;
   localparam int unsigned LDQ_INDEX = 4;
   localparam int unsigned LDQ_WIDTH = 8;
   localparam int unsigned LDQ_CNT_W = LDQ_INDEX + 1;

endpackage

// File: rtl/ldq_alloc_ctrl_wr_arb.sv
// Fixed-priority arbiter for the single load-queue RAM write port.
// The high-priority requester (update) wins the port even when it does not actually write.
module ldq_wr_arb
   import ldq_alloc_ctrl_pkg::*;
#(
   parameter int unsigned INDEX = LDQ_INDEX,
   parameter int unsigned WIDTH = LDQ_WIDTH
) (
   input  logic             kill,
   input  logic             hi_req,
   input  logic             hi_wr,
   input  logic [INDEX-1:0] hi_addr,
   input  logic [WIDTH-1:0] hi_data,
   input  logic             lo_req,
   input  logic [INDEX-1:0] lo_addr,
   input  logic [WIDTH-1:0] lo_data,
   output logic             hi_gnt,
   output logic             lo_gnt,
   output logic             we,
   output logic [INDEX-1:0] waddr,
   output logic [WIDTH-1:0] wdata
);

   assign hi_gnt = hi_req & ~kill;
   assign lo_gnt = lo_req & ~hi_req & ~kill;

   // hi_wr lets the owner of the port decline the write without releasing it
   assign we    = (hi_gnt & hi_wr) | lo_gnt;
   assign waddr = hi_gnt ? hi_addr : lo_addr;
   assign wdata = hi_gnt ? hi_data : lo_data;

endmodule

// File: rtl/ldq_alloc_ctrl.sv
// Load-queue allocation controller: head/tail/count/valid tracking and RAM write-port control.
// The load-queue RAM itself lives in the parent; this block only drives its ports.
module ldq_alloc_ctrl
   import ldq_alloc_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = LDQ_DEPTH,
   parameter int unsigned INDEX = LDQ_INDEX,
   parameter int unsigned WIDTH = LDQ_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_valid_i,
   input  logic [WIDTH-1:0] alloc_data_i,
   output logic             alloc_ready_o,
   output logic [INDEX-1:0] alloc_idx_o,
   input  logic             upd_valid_i,
   input  logic [INDEX-1:0] upd_idx_i,
   input  logic [WIDTH-1:0] upd_data_i,
   input  logic             retire_i,
   input  logic             flush_i,
   output logic             ram_we_o,
   output logic [INDEX-1:0] ram_waddr_o,
   output logic [WIDTH-1:0] ram_wdata_o,
   output logic [INDEX-1:0] ram_raddr_o,
   output logic [INDEX:0]   count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             upd_err_o
);

   localparam int unsigned CNT_W = INDEX + 1;

   logic [INDEX-1:0] head, head_nxt;
   logic [INDEX-1:0] tail, tail_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [DEPTH-1:0] valid, valid_nxt;
   logic             upd_err, upd_err_nxt;

   logic kill;
   logic retire_eff;
   logic upd_hit;
   logic upd_sup;
   logic upd_gnt;
   logic alloc_acc;

   assign full_o  = (count == CNT_W'(DEPTH));
   assign empty_o = (count == '0);

   // reset and flush both discard every request presented in the same cycle
   assign kill       = reset | flush_i;
   assign retire_eff = retire_i & ~empty_o & ~kill;
   assign upd_hit    = valid[upd_idx_i];
   assign upd_sup    = retire_eff & (upd_idx_i == head);

   assign alloc_ready_o = ~full_o & ~upd_valid_i & ~kill;

   ldq_wr_arb #(
      .INDEX (INDEX),
      .WIDTH (WIDTH)
   ) u_wr_arb (
      .kill    (kill),
      .hi_req  (upd_valid_i),
      .hi_wr   (upd_hit & ~upd_sup),
      .hi_addr (upd_idx_i),
      .hi_data (upd_data_i),
      .lo_req  (alloc_valid_i & ~full_o),
      .lo_addr (tail),
      .lo_data (alloc_data_i),
      .hi_gnt  (upd_gnt),
      .lo_gnt  (alloc_acc),
      .we      (ram_we_o),
      .waddr   (ram_waddr_o),
      .wdata   (ram_wdata_o)
   );

   // next-state for the queue pointers, occupancy and sticky error
   always_comb begin
      head_nxt    = head;
      tail_nxt    = tail;
      count_nxt   = count;
      valid_nxt   = valid;
      upd_err_nxt = upd_err;

      if (flush_i) begin
         head_nxt  = '0;
         tail_nxt  = '0;
         count_nxt = '0;
         valid_nxt = '0;
      end else begin
         if (alloc_acc) begin
            valid_nxt[tail] = 1'b1;
            tail_nxt        = tail + INDEX'(1);
         end
         if (retire_eff) begin
            valid_nxt[head] = 1'b0;
            head_nxt        = head + INDEX'(1);
         end
         case ({alloc_acc, retire_eff})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
         endcase
         if (upd_gnt && !upd_hit) begin
            upd_err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         valid   <= '0;
         upd_err <= 1'b0;
      end else begin
         head    <= head_nxt;
         tail    <= tail_nxt;
         count   <= count_nxt;
         valid   <= valid_nxt;
         upd_err <= upd_err_nxt;
      end
   end

   assign alloc_idx_o = tail;
   assign ram_raddr_o = head;
   assign count_o     = count;
   assign upd_err_o   = upd_err;

endmodule

// File: tb/tb_ldq_alloc_ctrl.sv
// Directed self-checking bench for ldq_alloc_ctrl with hand-computed expectations.
module tb_ldq_alloc_ctrl;

   logic       clk;
   logic       reset;
   logic       alloc_valid_i;
   logic [7:0] alloc_data_i;
   logic       alloc_ready_o;
   logic [3:0] alloc_idx_o;
   logic       upd_valid_i;
   logic [3:0] upd_idx_i;
   logic [7:0] upd_data_i;
   logic       retire_i;
   logic       flush_i;
   logic       ram_we_o;
   logic [3:0] ram_waddr_o;
   logic [7:0] ram_wdata_o;
   logic [3:0] ram_raddr_o;
   logic [4:0] count_o;
   logic       full_o;
   logic       empty_o;
   logic       upd_err_o;

   int checks;
   int failures;

   ldq_alloc_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .alloc_valid_i (alloc_valid_i),
      .alloc_data_i  (alloc_data_i),
      .alloc_ready_o (alloc_ready_o),
      .alloc_idx_o   (alloc_idx_o),
      .upd_valid_i   (upd_valid_i),
      .upd_idx_i     (upd_idx_i),
      .upd_data_i    (upd_data_i),
      .retire_i      (retire_i),
      .flush_i       (flush_i),
      .ram_we_o      (ram_we_o),
      .ram_waddr_o   (ram_waddr_o),
      .ram_wdata_o   (ram_wdata_o),
      .ram_raddr_o   (ram_raddr_o),
      .count_o       (count_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .upd_err_o     (upd_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock edge, then settle so state and comb outputs are stable
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid_i = 1'b0;
      upd_valid_i   = 1'b0;
      retire_i      = 1'b0;
      flush_i       = 1'b0;
      #1;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      alloc_valid_i = 1'b1;
      alloc_data_i  = 8'h55;
      upd_valid_i   = 1'b0;
      upd_idx_i     = 4'd0;
      upd_data_i    = 8'h00;
      retire_i      = 1'b0;
      flush_i       = 1'b0;

      // held in reset with an allocation pending
      tick();
      tick();
      chk("rst_ready", 32'(alloc_ready_o), 32'd0);
      chk("rst_we", 32'(ram_we_o), 32'd0);
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_full", 32'(full_o), 32'd0);

      reset = 1'b0;
      idle();
      chk("post_rst_ready", 32'(alloc_ready_o), 32'd1);
      chk("post_rst_count", 32'(count_o), 32'd0);
      chk("post_rst_tail", 32'(alloc_idx_o), 32'd0);
      chk("post_rst_head", 32'(ram_raddr_o), 32'd0);
      chk("post_rst_err", 32'(upd_err_o), 32'd0);

      // 16 back-to-back allocations fill the queue
      for (int i = 0; i < 16; i++) begin
         alloc_valid_i = 1'b1;
         alloc_data_i  = 8'(8'h10 + i);
         #1;
         chk("fill_ready", 32'(alloc_ready_o), 32'd1);
         chk("fill_idx", 32'(alloc_idx_o), 32'(i));
         chk("fill_we", 32'(ram_we_o), 32'd1);
         chk("fill_waddr", 32'(ram_waddr_o), 32'(i));
         chk("fill_wdata", 32'(ram_wdata_o), 32'(8'h10 + i));
         tick();
      end
      chk("full_flag", 32'(full_o), 32'd1);
      chk("full_count", 32'(count_o), 32'd16);
      chk("full_ready", 32'(alloc_ready_o), 32'd0);
      chk("full_we", 32'(ram_we_o), 32'd0);

      // retire plus alloc on a full queue: alloc is refused this cycle
      retire_i     = 1'b1;
      alloc_data_i = 8'h20;
      #1;
      chk("full_ret_ready", 32'(alloc_ready_o), 32'd0);
      chk("full_ret_we", 32'(ram_we_o), 32'd0);
      tick();
      chk("after_ret_count", 32'(count_o), 32'd15);
      chk("after_ret_head", 32'(ram_raddr_o), 32'd1);
      chk("after_ret_tail", 32'(alloc_idx_o), 32'd0);

      retire_i = 1'b0;
      #1;
      chk("refill_ready", 32'(alloc_ready_o), 32'd1);
      chk("refill_waddr", 32'(ram_waddr_o), 32'd0);
      tick();
      chk("refill_count", 32'(count_o), 32'd16);
      chk("refill_head", 32'(ram_raddr_o), 32'd1);
      chk("refill_tail", 32'(alloc_idx_o), 32'd1);

      // retire two: head 3, count 14, tail 1
      alloc_valid_i = 1'b0;
      retire_i      = 1'b1;
      tick();
      tick();
      chk("ret2_head", 32'(ram_raddr_o), 32'd3);
      chk("ret2_count", 32'(count_o), 32'd14);

      // alloc and update entry 3 together: update owns the port
      retire_i      = 1'b0;
      alloc_valid_i = 1'b1;
      alloc_data_i  = 8'h77;
      upd_valid_i   = 1'b1;
      upd_idx_i     = 4'd3;
      upd_data_i    = 8'hA5;
      #1;
      chk("upd_we", 32'(ram_we_o), 32'd1);
      chk("upd_waddr", 32'(ram_waddr_o), 32'd3);
      chk("upd_wdata", 32'(ram_wdata_o), 32'hA5);
      chk("upd_ready", 32'(alloc_ready_o), 32'd0);
      tick();
      chk("upd_tail", 32'(alloc_idx_o), 32'd1);
      chk("upd_count", 32'(count_o), 32'd14);

      // update to head while head retires: suppressed, no error
      alloc_valid_i = 1'b0;
      retire_i      = 1'b1;
      #1;
      chk("sup_we", 32'(ram_we_o), 32'd0);
      tick();
      chk("sup_err", 32'(upd_err_o), 32'd0);
      chk("sup_head", 32'(ram_raddr_o), 32'd4);
      chk("sup_count", 32'(count_o), 32'd13);

      // retire ten more to reach head 14, then one alloc to wrap tail to 2
      upd_valid_i = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      retire_i      = 1'b0;
      alloc_valid_i = 1'b1;
      alloc_data_i  = 8'h33;
      #1;
      chk("wrap_pre_head", 32'(ram_raddr_o), 32'd14);
      chk("wrap_pre_count", 32'(count_o), 32'd3);
      tick();
      chk("wrap_tail", 32'(alloc_idx_o), 32'd2);
      chk("wrap_count", 32'(count_o), 32'd4);

      // flush with an alloc pending
      flush_i = 1'b1;
      #1;
      chk("flush_we", 32'(ram_we_o), 32'd0);
      chk("flush_ready", 32'(alloc_ready_o), 32'd0);
      tick();
      idle();
      chk("flush_head", 32'(ram_raddr_o), 32'd0);
      chk("flush_tail", 32'(alloc_idx_o), 32'd0);
      chk("flush_empty", 32'(empty_o), 32'd1);
      chk("flush_count", 32'(count_o), 32'd0);

      // update to invalid entry 9 on an empty queue
      upd_valid_i = 1'b1;
      upd_idx_i   = 4'd9;
      upd_data_i  = 8'hEE;
      #1;
      chk("inv_we", 32'(ram_we_o), 32'd0);
      chk("inv_ready", 32'(alloc_ready_o), 32'd0);
      chk("inv_err_pre", 32'(upd_err_o), 32'd0);
      tick();
      idle();
      chk("inv_err_set", 32'(upd_err_o), 32'd1);
      tick();
      chk("inv_err_sticky", 32'(upd_err_o), 32'd1);
      flush_i = 1'b1;
      tick();
      idle();
      chk("inv_err_flush", 32'(upd_err_o), 32'd1);

      // retire while empty is ignored
      retire_i = 1'b1;
      tick();
      idle();
      chk("mt_ret_head", 32'(ram_raddr_o), 32'd0);
      chk("mt_ret_count", 32'(count_o), 32'd0);
      chk("mt_ret_empty", 32'(empty_o), 32'd1);

      // two allocs, then reset asserted mid-allocation
      alloc_valid_i = 1'b1;
      alloc_data_i  = 8'h44;
      tick();
      tick();
      chk("pre_rst_tail", 32'(alloc_idx_o), 32'd2);
      reset = 1'b1;
      #1;
      chk("mid_rst_we", 32'(ram_we_o), 32'd0);
      chk("mid_rst_ready", 32'(alloc_ready_o), 32'd0);
      tick();
      reset = 1'b0;
      idle();
      chk("mid_rst_tail", 32'(alloc_idx_o), 32'd0);
      chk("mid_rst_count", 32'(count_o), 32'd0);
      chk("mid_rst_err", 32'(upd_err_o), 32'd0);
      chk("mid_rst_ready_after", 32'(alloc_ready_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ldq_alloc_ctrl.md
LDQ_ALLOC_CTRL -- requirements
Module: ldq_alloc_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, load-queue entries (power of 2); INDEX, 4, log2(DEPTH); WIDTH, 8, entry payload bits.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alloc_valid_i  in  1  dispatch requests one new entry.
REQ-005 alloc_data_i  in  WIDTH  payload for the new entry.
REQ-006 alloc_ready_o  out  1  allocation accepted this cycle when high together with alloc_valid_i.
REQ-007 alloc_idx_o  out  INDEX  entry index assigned to the current allocation (equals tail).
REQ-008 upd_valid_i / upd_idx_i / upd_data_i  in  1/INDEX/WIDTH  execute-stage payload update of an existing entry.
REQ-009 retire_i  in  1  commit retires the head entry.
REQ-010 flush_i  in  1  recovery; discards all entries.
REQ-011 ram_we_o / ram_waddr_o / ram_wdata_o  out  1/INDEX/WIDTH  drive the RAM single write port.
REQ-012 ram_raddr_o  out  INDEX  drives RAM read port 0 with the head index.
REQ-013 count_o / full_o / empty_o  out  INDEX+1/1/1  occupancy status.
REQ-014 upd_err_o  out  1  sticky: an update targeted an invalid entry.

Function
REQ-015 State: head, tail (INDEX bits each, wrap modulo DEPTH), count (INDEX+1 bits), valid vector (DEPTH bits).
REQ-016 full_o = (count == DEPTH); empty_o = (count == 0); both combinational from registered count.
REQ-017 Write-port sharing: an update SHALL have priority; alloc_ready_o = !full_o && !upd_valid_i && !flush_i && !reset.
REQ-018 Accepted allocation: the RAM write is at tail with alloc_data_i in the same cycle (combinational); on the next edge valid[tail] = 1 and tail = tail+1.
REQ-019 Update: when valid[upd_idx_i] = 1, the RAM write is at upd_idx_i with upd_data_i; otherwise no write occurs and upd_err_o sets on the next edge.
REQ-020 Retire: when retire_i and !empty_o, valid[head] clears and head = head+1 on the next edge; a retire while empty is ignored.
REQ-021 An update to the head entry in the same cycle as a retire SHALL be suppressed; this is not an error.
REQ-022 count: +1 on accepted alloc, -1 on effective retire, unchanged when both occur.
REQ-023 A retire on a full queue SHALL NOT enable same-cycle allocation; ready is evaluated from the registered count.
REQ-024 flush_i SHALL override all others: no RAM write; next edge head = tail = 0, count = 0, valid = 0; upd_err_o is unaffected.
REQ-025 ram_we_o SHALL be 0 whenever reset or flush_i is high.
REQ-026 ram_raddr_o = head; head payload appears on RAM data0 combinationally.

Reset
REQ-027 On reset: head = tail = 0, count = 0, valid = 0, upd_err_o = 0.
REQ-028 During reset: alloc_ready_o = 0, ram_we_o = 0, empty_o = 1, full_o = 0; alloc_ready_o = 1 in the first cycle after reset.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight requests in that cycle.

Structure
REQ-030 DEPTH/INDEX/WIDTH defaults and the count width SHALL live in the shared LSQ package.
REQ-031 The write-port priority mux SHALL be one sub-module: ldq_wr_arb (two requesters, fixed priority, grant outputs).
REQ-032 The block SHALL instantiate no RAM; the parent connects ram_* ports to the load-queue RAM.

Verification
REQ-033 After reset, 16 back-to-back allocs (data 0x10..0x1F) -> alloc_idx_o 0..15, full_o = 1 after the 16th, alloc_ready_o = 0 after that.
REQ-034 Full queue, retire 1 and alloc 1 with head at 0 -> next cycle count = 16, head = 1, tail = 1; ram_raddr_o = 1.
REQ-035 Alloc and update to valid entry 3 in the same cycle -> ram_waddr_o = 3 carries upd_data_i, alloc_ready_o = 0, tail unchanged.
REQ-036 Update to invalid entry 9 with the queue empty -> ram_we_o = 0, upd_err_o = 1 next cycle and remains 1.
REQ-037 Head = 14, tail = 2 (wrap), flush_i with alloc_valid_i -> no write; next cycle head = tail = 0, empty_o = 1.
REQ-038 Retire while empty -> head, count unchanged; reset mid-alloc -> tail = 0, no RAM write.
